// File: rtl/mpc_mul_share_arb.sv
// Shared pipelined signed multiplier front-end.
// Round-robin arbitration over N_REQ operand requesters drives one external multiplier.
// A tag pipe carries each requester ID alongside its product. The whole pipeline stalls
// while a presented result is not accepted.
module mpc_mul_share_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned A_W     = 21,
    parameter int unsigned B_W     = 13,
    parameter int unsigned P_W     = A_W + B_W,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*A_W-1:0]   req_a,
    input  logic [N_REQ*B_W-1:0]   req_b,
    output logic                   mul_ce,
    output logic [A_W-1:0]         mul_a,
    output logic [B_W-1:0]         mul_b,
    input  logic [P_W-1:0]         mul_p,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [P_W-1:0]         res_p,
    output logic [ID_W:0]          inflight
);

    logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [MUL_LAT-1:0]            tag_vld_q, tag_vld_d;
    logic [MUL_LAT-1:0][ID_W-1:0]  tag_id_q, tag_id_d;
    logic [ID_W:0]                 inflight_q, inflight_d;
    // Low for the first cycle after reset so no grant is issued before the first edge.
    logic                          run_q;

    logic                          grant_any;
    logic [ID_W-1:0]               grant_id;
    logic                          gnt_vld;
    logic                          accept;
    logic                          res_hs;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(rr_ptr_q) + k) % N_REQ;
            if (!grant_any && req_valid[idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = idx[ID_W-1:0];
            end
        end
    end

    assign res_valid = tag_vld_q[MUL_LAT-1];
    assign res_id    = tag_id_q[MUL_LAT-1];
    assign res_p     = mul_p;
    assign mul_ce    = ~(res_valid & ~res_ready);
    assign gnt_vld   = grant_any & run_q;
    assign accept    = gnt_vld & mul_ce;
    assign res_hs    = res_valid & res_ready;
    assign inflight  = inflight_q;

    // Grant decode and operand mux towards the multiplier.
    always_comb begin
        req_ready = '0;
        mul_a     = '0;
        mul_b     = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
        if (gnt_vld) begin
            mul_a = req_a[32'(grant_id)*A_W +: A_W];
            mul_b = req_b[32'(grant_id)*B_W +: B_W];
        end
    end

    // Next state: pointer advance, tag shift in lock-step with mul_ce, in-flight count.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        tag_vld_d  = tag_vld_q;
        tag_id_d   = tag_id_q;
        inflight_d = inflight_q;
        if (accept) begin
            rr_ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
        if (mul_ce) begin
            for (int unsigned i = 1; i < MUL_LAT; i++) begin
                tag_vld_d[i] = tag_vld_q[i-1];
                tag_id_d[i]  = tag_id_q[i-1];
            end
            tag_vld_d[0] = gnt_vld;
            tag_id_d[0]  = grant_id;
        end
        if (accept && !res_hs) begin
            inflight_d = inflight_q + (ID_W+1)'(1);
        end else if (!accept && res_hs) begin
            inflight_d = inflight_q - (ID_W+1)'(1);
        end
    end

    // State registers; reset drops every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q   <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            inflight_q <= '0;
            run_q      <= 1'b0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            inflight_q <= inflight_d;
            run_q      <= 1'b1;
        end
    end

endmodule
